multiplier_arbiter: RTL
=======================

// Module: multiplier_arbiter
// PURPOSE
//  Shares one 8x8 multiplier_module among NUM_REQ requesters using round-robin arbitration.
//  Latches the winner's operands and drives the multiplier start/done handshake.
//  Returns the product to the winner with a one-cycle ack, and recovers from a hung multiplier via a watchdog.
//  Sits between several producer blocks (e.g. FIFO-fed interfaces) and a single shared multiplier instance.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  ID_W      2    requester index width, >= clog2(NUM_REQ)
//  DATA_W    8    operand width; product is 2*DATA_W
//  TIMEOUT   255  max RUN cycles waiting for mult_done before abort (1..255)
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  asynchronous, active-low reset
//  req           in   NUM_REQ            per-requester request, held until own ack
//  op_a          in   NUM_REQ*DATA_W     multiplicands, requester k at [k*DATA_W +: DATA_W]
//  op_b          in   NUM_REQ*DATA_W     multipliers, same packing
//  ack           out  NUM_REQ            one-hot 1-cycle pulse: result for requester k valid
//  result        out  2*DATA_W           product for acked requester, held until next ack
//  result_id     out  ID_W               index of last acked requester
//  err           out  1                  1-cycle pulse with ack when the operation timed out
//  busy          out  1                  high in any state other than IDLE
//  mult_start    out  1                  start to shared multiplier, level, held until done
//  mult_a        out  DATA_W             latched multiplicand
//  mult_b        out  DATA_W             latched multiplier
//  mult_done     in   1                  multiplier completion (level or pulse)
//  mult_product  in   2*DATA_W           multiplier result, valid while mult_done=1
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0 (ack, result, result_id, err, busy, mult_start, mult_a, mult_b).
//  FSM IDLE -> RUN -> DONE -> IDLE. Reset mid-operation returns to IDLE at once, with mult_start=0.
//  IDLE
//   - If any req is high, pick the first set bit scanning from rr_ptr upward, with wrap.
//   - Latch grant_id, op_a/op_b slice -> mult_a/mult_b. Go to RUN. Clear watchdog.
//   - No req: stay in IDLE.
//  RUN
//   - mult_start=1 every cycle.
//   - mult_done=1: register mult_product -> result, grant_id -> result_id, mult_start<=0, go to DONE.
//   - Else wdog++. At wdog==TIMEOUT: result<=0, set err flag, mult_start<=0, go to DONE.
//  DONE
//   - ack[grant_id]=1 for this cycle only; err=1 if timeout.
//   - rr_ptr <= grant_id+1 (wraps to 0 past NUM_REQ-1). Go to IDLE.
//  Latency
//   - req sampled in IDLE at edge N, mult_start high from cycle N+1.
//   - mult_done seen at edge M, ack/result visible in cycle M+1.
//   - Next grant is decided at the end of cycle M+2.
//  Requester rules
//   - Operands are sampled only at grant; changes afterwards are ignored.
//   - Dropping req before grant withdraws the request.
//   - Dropping req after grant does not cancel; ack still pulses.
//   - Requester must drop req (or present a new op) on the cycle after its ack.
//  Fairness
//   - The winner gets lowest priority next round.
//   - With all req held high, grants cycle 0,1,2,3,0,...
//  mult_done while IDLE or DONE is ignored. mult_product is never sampled outside RUN.
//  Product width is 2*DATA_W, unsigned; no truncation.
// TESTING
//  1 Reset: assert rst_n=0 mid-RUN -> all outputs 0, state IDLE next cycle, mult_start=0.
//  2 Single request: req=4'b0100, a=0x0C, b=0x0A; model done 8 cycles later
//    -> mult_a=0x0C, mult_b=0x0A; ack=4'b0100; result=0x0078; result_id=2; err=0.
//  3 Round-robin: req=4'b1111 held, distinct operands -> ack order 0,1,2,3,0.
//    Each result matches its own a*b (e.g. 0xFF*0xFF=0xFE01).
//  4 Competition after grant: req[1] granted, then req[0] raised -> req[0] served next; no preemption of 1.
//  5 Timeout: mult_done stuck 0 -> mult_start falls after 255 RUN cycles; ack+err pulse; result=0.
//    Next request then proceeds normally.
//  6 Operand change after grant: change op_a[k] during RUN -> result uses the originally latched value.

Source files
------------

// File: rtl/multiplier_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multiplier_arbiter_if
// Brief    : Requester bus plus shared-multiplier handshake for the arbiter.
// Revision : 1.0
// ============================================================================
interface multiplier_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] op_a;
    logic [NUM_REQ*DATA_W-1:0] op_b;
    logic [NUM_REQ-1:0]        ack;
    logic [2*DATA_W-1:0]       result;
    logic [ID_W-1:0]           result_id;
    logic                      err;
    logic                      busy;
    logic                      mult_start;
    logic [DATA_W-1:0]         mult_a;
    logic [DATA_W-1:0]         mult_b;
    logic                      mult_done;
    logic [2*DATA_W-1:0]       mult_product;

    // Arbiter side
    modport slave (
        input  req, op_a, op_b, mult_done, mult_product,
        output ack, result, result_id, err, busy, mult_start, mult_a, mult_b
    );

    // Requesters and multiplier side
    modport master (
        output req, op_a, op_b, mult_done, mult_product,
        input  ack, result, result_id, err, busy, mult_start, mult_a, mult_b
    );
endinterface
`default_nettype wire

// File: rtl/multiplier_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multiplier_arbiter
// Brief    : Round-robin sharing of one multiplier with a hang watchdog.
// Revision : 1.0
// ============================================================================
module multiplier_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multiplier_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     result_id_q, result_id_d;
    logic [DATA_W-1:0]   mult_a_q, mult_a_d;
    logic [DATA_W-1:0]   mult_b_q, mult_b_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                mult_start_q, mult_start_d;
    logic                timeout_q, timeout_d;
    logic [7:0]          wdog_q, wdog_d;

    logic [DATA_W-1:0]   w_op_a [NUM_REQ];
    logic [DATA_W-1:0]   w_op_b [NUM_REQ];
    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [ID_W:0]       w_scan;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign w_op_a[k] = bus.op_a[k*DATA_W +: DATA_W];
        assign w_op_b[k] = bus.op_b[k*DATA_W +: DATA_W];
    end

    // First active request at or above rr_ptr, wrapping past NUM_REQ-1
    always_comb begin : p_arb
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.req[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin : p_fsm
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        result_id_d  = result_id_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        result_d     = result_q;
        mult_start_d = mult_start_q;
        timeout_d    = timeout_q;
        wdog_d       = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_id_d   = w_pick;
                    mult_a_d     = w_op_a[w_pick];
                    mult_b_d     = w_op_b[w_pick];
                    wdog_d       = '0;
                    timeout_d    = 1'b0;
                    mult_start_d = 1'b1;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.mult_done) begin
                    result_d     = bus.mult_product;
                    result_id_d  = grant_id_q;
                    mult_start_d = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                    if (wdog_d == 8'(TIMEOUT)) begin
                        result_d     = '0;
                        result_id_d  = grant_id_q;
                        timeout_d    = 1'b1;
                        mult_start_d = 1'b0;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + ID_W'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            result_id_q  <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            result_q     <= '0;
            mult_start_q <= 1'b0;
            timeout_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            result_id_q  <= result_id_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            result_q     <= result_d;
            mult_start_q <= mult_start_d;
            timeout_q    <= timeout_d;
            wdog_q       <= wdog_d;
        end
    end

    assign bus.ack        = (state_q == S_DONE) ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign bus.err        = (state_q == S_DONE) && timeout_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.result     = result_q;
    assign bus.result_id  = result_id_q;
    assign bus.mult_start = mult_start_q;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;

endmodule
`default_nettype wire
